// File: rtl/crc_chk_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crc_chk_pkg
// Description : Shared types and the width-generic serial CRC step used by the
//               serial CRC checker and its accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package crc_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_CMP   = 2'd2
    } state_t;

    // Widest CRC the generic step supports; narrower CRCs zero-extend into it.
    localparam int c_crc_max_w = 32;

    function automatic int bit_cnt_width(input int data_width);
        return (data_width < 2) ? 1 : $clog2(data_width);
    endfunction

    // One MSB-first step. Bits at and above 'width' are forced to zero.
    function automatic logic [c_crc_max_w-1:0] crc_serial_step(
        input logic [c_crc_max_w-1:0] acc,
        input logic                   d,
        input logic [c_crc_max_w-1:0] poly,
        input int                     width
    );
        logic                   fb;
        logic [c_crc_max_w-1:0] nxt;
        logic [c_crc_max_w-1:0] mask;
        fb   = d;
        mask = '0;
        for (int i = 0; i < c_crc_max_w; i++) begin
            if (i == width - 1) begin
                fb = fb ^ acc[i];
            end
            mask[i] = (i < width);
        end
        nxt = (acc << 1) ^ (fb ? poly : '0);
        return nxt & mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/crc_lfsr_serial.sv
`default_nettype none
// ============================================================================
// Module      : crc_lfsr_serial
// Description : Bit-serial CRC accumulator with load-init and step controls.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_lfsr_serial
    import crc_chk_pkg::*;
#(
    parameter int                         POLYNOMIAL_BITS = 1,
    parameter logic [POLYNOMIAL_BITS-1:0] POLY            = {POLYNOMIAL_BITS{1'b1}},
    parameter logic [POLYNOMIAL_BITS-1:0] CRC_INIT        = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_init,
    input  logic                       i_step,
    input  logic                       i_bit,
    output logic [POLYNOMIAL_BITS-1:0] o_acc
);

    logic [POLYNOMIAL_BITS-1:0] r_acc;
    logic [c_crc_max_w-1:0]     w_acc_ext;
    logic [c_crc_max_w-1:0]     w_poly_ext;
    logic [c_crc_max_w-1:0]     w_step;
    logic                       w_unused_step_hi;

    always_comb begin
        w_acc_ext                        = '0;
        w_acc_ext[POLYNOMIAL_BITS-1:0]   = r_acc;
        w_poly_ext                       = '0;
        w_poly_ext[POLYNOMIAL_BITS-1:0]  = POLY;
    end

    assign w_step           = crc_serial_step(w_acc_ext, i_bit, w_poly_ext, POLYNOMIAL_BITS);
    // Upper bits are always zero after masking; folded here only to keep them referenced.
    assign w_unused_step_hi = ^w_step;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (i_init) begin
            r_acc <= CRC_INIT;
        end else if (i_step) begin
            r_acc <= w_step[POLYNOMIAL_BITS-1:0];
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/crc_serial_checker.sv
`default_nettype none
// ============================================================================
// Module      : crc_serial_checker
// Description : Captures a stored word and CRC, recomputes the CRC bit-serially
//               MSB first, and reports match/mismatch with sticky error tracking.
// Revision    : 1.0 - initial release
// ============================================================================
module crc_serial_checker
    import crc_chk_pkg::*;
#(
    parameter int                         DATA_WIDTH      = 8,
    parameter int                         POLYNOMIAL_BITS = 1,
    parameter logic [POLYNOMIAL_BITS-1:0] POLY            = {POLYNOMIAL_BITS{1'b1}},
    parameter logic [POLYNOMIAL_BITS-1:0] CRC_INIT        = '0,
    parameter int                         CNT_WIDTH       = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       chk_start,
    input  logic [DATA_WIDTH-1:0]      mem_data_out,
    input  logic [POLYNOMIAL_BITS-1:0] crc_data_out,
    input  logic                       err_clr,
    output logic                       chk_busy,
    output logic                       chk_done,
    output logic                       crc_err,
    output logic [POLYNOMIAL_BITS-1:0] crc_calc,
    output logic                       err_sticky,
    output logic [CNT_WIDTH-1:0]       err_count
);

    localparam int                     c_bit_cnt_w = bit_cnt_width(DATA_WIDTH);
    localparam logic [c_bit_cnt_w-1:0] c_last_bit  = c_bit_cnt_w'(DATA_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0]   c_cnt_max   = '1;

    state_t                     r_state;
    state_t                     w_state_next;

    logic [DATA_WIDTH-1:0]      r_shadow_data;
    logic [POLYNOMIAL_BITS-1:0] r_shadow_crc;
    logic [c_bit_cnt_w-1:0]     r_bit_cnt;

    logic                       r_chk_done;
    logic                       r_crc_err;
    logic [POLYNOMIAL_BITS-1:0] r_crc_calc;
    logic                       r_err_sticky;
    logic [CNT_WIDTH-1:0]       r_err_count;

    logic                       w_accept;
    logic                       w_busy;
    logic                       w_in_shift;
    logic                       w_in_cmp;
    logic                       w_mismatch;
    logic [POLYNOMIAL_BITS-1:0] w_acc;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:  if (chk_start) w_state_next = ST_SHIFT;
            ST_SHIFT: if (r_bit_cnt == '0) w_state_next = ST_CMP;
            ST_CMP:   w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_accept   = 1'b0;
        w_busy     = 1'b0;
        w_in_shift = 1'b0;
        w_in_cmp   = 1'b0;
        case (r_state)
            ST_IDLE:  w_accept   = chk_start;
            ST_SHIFT: begin
                w_busy     = 1'b1;
                w_in_shift = 1'b1;
            end
            ST_CMP:   begin
                w_busy   = 1'b1;
                w_in_cmp = 1'b1;
            end
            default:  w_busy = 1'b0;
        endcase
    end

    // ----------------------------------------------------- capture / counter
    // Inputs are sampled only on acceptance so later memory writes cannot leak in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_data <= '0;
            r_shadow_crc  <= '0;
            r_bit_cnt     <= '0;
        end else if (w_accept) begin
            r_shadow_data <= mem_data_out;
            r_shadow_crc  <= crc_data_out;
            r_bit_cnt     <= c_last_bit;
        end else if (w_in_shift && (r_bit_cnt != '0)) begin
            r_bit_cnt     <= r_bit_cnt - 1'b1;
        end
    end

    crc_lfsr_serial #(
        .POLYNOMIAL_BITS (POLYNOMIAL_BITS),
        .POLY            (POLY),
        .CRC_INIT        (CRC_INIT)
    ) u_lfsr (
        .clk    (clk),
        .rst    (rst),
        .i_init (w_accept),
        .i_step (w_in_shift),
        .i_bit  (r_shadow_data[r_bit_cnt]),
        .o_acc  (w_acc)
    );

    assign w_mismatch = w_in_cmp && (w_acc != r_shadow_crc);

    // --------------------------------------------------------------- result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_chk_done <= 1'b0;
            r_crc_err  <= 1'b0;
            r_crc_calc <= '0;
        end else begin
            r_chk_done <= w_in_cmp;
            if (w_in_cmp) begin
                r_crc_err  <= (w_acc != r_shadow_crc);
                r_crc_calc <= w_acc;
            end
        end
    end

    // A clear coinciding with a mismatch counts that mismatch as the first one.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end else if (w_mismatch) begin
            r_err_sticky <= 1'b1;
            if (err_clr) begin
                r_err_count <= CNT_WIDTH'(1);
            end else if (r_err_count != c_cnt_max) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end else if (err_clr) begin
            r_err_sticky <= 1'b0;
            r_err_count  <= '0;
        end
    end

    assign chk_busy   = w_busy;
    assign chk_done   = r_chk_done;
    assign crc_err    = r_crc_err;
    assign crc_calc   = r_crc_calc;
    assign err_sticky = r_err_sticky;
    assign err_count  = r_err_count;

endmodule
`default_nettype wire
